// File: rtl/mnist_pkg.sv
// Shared constants and loader state encoding for the MNIST frame loader.
package mnist_pkg;
  localparam int         FRAME_BYTES = 784;
  localparam int         ADDR_W      = 10;
  localparam logic [7:0] SYNC0_DEF   = 8'hA5;
  localparam logic [7:0] SYNC1_DEF   = 8'h5A;

  typedef enum logic [1:0] {
    S_SYNC0,
    S_SYNC1,
    S_PAYLOAD,
    S_CHECK
  } ld_state_e;
endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle counter: fires when TIMEOUT_CYCLES idle cycles pass without a kick.
module rx_timeout_timer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);
  logic [23:0] cnt_q, cnt_d;

  // A byte arriving in the terminal cycle wins over expiry.
  assign expired = enable && !kick && (cnt_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    cnt_d = cnt_q + 24'd1;
    if (!enable || kick || expired) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mnist_frame_loader.sv
// UART byte-stream framer: finds SYNC0/SYNC1, writes the payload into the frame RAM,
// verifies the 8-bit checksum and flags a complete frame to the blitter.
module mnist_frame_loader #(
  parameter logic [7:0]  SYNC0          = mnist_pkg::SYNC0_DEF,
  parameter logic [7:0]  SYNC1          = mnist_pkg::SYNC1_DEF,
  parameter int          FRAME_BYTES    = mnist_pkg::FRAME_BYTES,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [9:0] ram_addr_a,
  output logic [7:0] ram_data_a,
  output logic       ram_we_a,
  output logic       frame_ready,
  output logic       loading,
  output logic       frame_done,
  output logic       err_checksum,
  output logic       err_timeout,
  output logic [7:0] frame_count
);
  import mnist_pkg::*;

  ld_state_e   state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        echk_q, echk_d;
  logic        eto_q, eto_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        expired;

  rx_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_q != S_SYNC0),
    .kick    (rx_valid),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    echk_d  = 1'b0;
    eto_d   = 1'b0;
    cnt_d   = cnt_q;
    if (expired) begin
      state_d = S_SYNC0;
      eto_d   = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        S_SYNC0: if (rx_data == SYNC0) state_d = S_SYNC1;
        S_SYNC1: begin
          if (rx_data == SYNC1) begin
            state_d = S_PAYLOAD;
            idx_d   = '0;
            sum_d   = '0;
          end else if (rx_data != SYNC0) begin
            state_d = S_SYNC0;
          end
        end
        S_PAYLOAD: begin
          addr_d = idx_q;
          data_d = rx_data;
          we_d   = 1'b1;
          sum_d  = sum_q + rx_data;
          // Drop frame_ready together with the first write so a partial frame is never shown.
          if (idx_q == '0) rdy_d = 1'b0;
          if (idx_q == 10'(FRAME_BYTES - 1)) state_d = S_CHECK;
          else                               idx_d   = idx_q + 10'd1;
        end
        S_CHECK: begin
          state_d = S_SYNC0;
          if (rx_data == sum_q) begin
            rdy_d  = 1'b1;
            done_d = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end else begin
            rdy_d  = 1'b0;
            echk_d = 1'b1;
          end
        end
        default: state_d = S_SYNC0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SYNC0;
      idx_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      echk_q  <= 1'b0;
      eto_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      echk_q  <= echk_d;
      eto_q   <= eto_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ram_addr_a   = addr_q;
  assign ram_data_a   = data_q;
  assign ram_we_a     = we_q;
  assign frame_ready  = rdy_q;
  assign loading      = (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign frame_done   = done_q;
  assign err_checksum = echk_q;
  assign err_timeout  = eto_q;
  assign frame_count  = cnt_q;
endmodule

// File: tb/tb_mnist_frame_loader.sv
// Scoreboard bench: a full-size loader for frame/error/reset scenarios and an
// 8-byte-frame loader for the 256-frame counter wrap.
module tb_mnist_frame_loader;
  localparam logic [23:0] TO = 24'd50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxv [2];
  logic [7:0] rxd [2];
  logic [9:0] addr [2];
  logic [7:0] data [2];
  logic       we [2], rdy [2], ld [2], done [2], echk [2], eto [2];
  logic [7:0] cnt [2];

  always #5 clk = ~clk;

  mnist_frame_loader #(.TIMEOUT_CYCLES(TO)) u0 (
    .clk(clk), .reset(reset), .rx_valid(rxv[0]), .rx_data(rxd[0]),
    .ram_addr_a(addr[0]), .ram_data_a(data[0]), .ram_we_a(we[0]),
    .frame_ready(rdy[0]), .loading(ld[0]), .frame_done(done[0]),
    .err_checksum(echk[0]), .err_timeout(eto[0]), .frame_count(cnt[0])
  );

  mnist_frame_loader #(.FRAME_BYTES(8), .TIMEOUT_CYCLES(TO)) u1 (
    .clk(clk), .reset(reset), .rx_valid(rxv[1]), .rx_data(rxd[1]),
    .ram_addr_a(addr[1]), .ram_data_a(data[1]), .ram_we_a(we[1]),
    .frame_ready(rdy[1]), .loading(ld[1]), .frame_done(done[1]),
    .err_checksum(echk[1]), .err_timeout(eto[1]), .frame_count(cnt[1])
  );

  typedef struct packed {logic [9:0] a; logic [7:0] v;} wr_t;
  // kind: 0 good frame, 1 checksum error, 2 timeout
  typedef struct packed {logic [1:0] kind; logic [7:0] fc; logic r;} ev_t;

  wr_t wq[$];
  ev_t eq[$];
  wr_t w;
  ev_t e;
  int  checks = 0;
  int  errors = 0;
  int  m_cnt [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: only one loader is driven at a time, so a single pair of queues serves both.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d] === 1'b1) begin
        if (wq.size() == 0) chk("unexpected write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("write addr", int'(addr[d]), int'(w.a));
          chk("write data", int'(data[d]), int'(w.v));
          if (addr[d] == 10'd0) chk("ready low at first write", int'(rdy[d]), 0);
        end
      end
      if ((done[d] | echk[d] | eto[d]) === 1'b1) begin
        if (eq.size() == 0) chk("unexpected event", 1, 0);
        else begin
          e = eq.pop_front();
          chk("event kind", int'({eto[d], echk[d], done[d]}), 1 << e.kind);
          chk("event frame_count", int'(cnt[d]), int'(e.fc));
          chk("event frame_ready", int'(rdy[d]), int'(e.r));
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b);
    rxv[d] = 1'b1;
    rxd[d] = b;
    @(posedge clk);
    #1;
    rxv[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: byte i = i mod 256, else random. bad = offset added to the checksum.
  task automatic frame(input int d, input int mode, input int bad, input int gap, input int stall_at);
    int         fb;
    logic [7:0] b;
    logic [7:0] sum;
    fb  = (d != 0) ? 8 : 784;
    sum = 8'd0;
    send(d, 8'hA5);
    send(d, 8'h5A);
    for (int i = 0; i < fb; i++) begin
      b = (mode == 0) ? 8'(i) : 8'($urandom);
      wq.push_back('{10'(i), b});
      sum = sum + b;
      send(d, b);
      if (i == stall_at) idle(int'(TO) - 1);
      else if (gap > 0) idle($urandom_range(0, gap));
    end
    if (bad == 0) begin
      m_cnt[d] = (m_cnt[d] + 1) % 256;
      eq.push_back('{2'd0, 8'(m_cnt[d]), 1'b1});
    end else begin
      eq.push_back('{2'd1, 8'(m_cnt[d]), 1'b0});
    end
    send(d, sum + 8'(bad));
  endtask

  task automatic garbage(input int n);
    logic [7:0] g;
    repeat (n) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h00;
      send(0, g);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rxv[0] = 1'b0; rxv[1] = 1'b0;
    rxd[0] = 8'h00; rxd[1] = 8'h00;
    m_cnt[0] = 0; m_cnt[1] = 0;
    reset = 1'b1;
    idle(3);
    chk("reset frame_ready", int'(rdy[0]), 0);
    chk("reset frame_count", int'(cnt[0]), 0);
    chk("reset loading", int'(ld[0]), 0);
    chk("reset we", int'(we[0]), 0);
    reset = 1'b0;
    idle(2);

    // Ramp frame with correct checksum.
    frame(0, 0, 0, 0, -1);
    idle(2);
    chk("ready after good frame", int'(rdy[0]), 1);
    chk("count after good frame", int'(cnt[0]), 1);
    chk("loading idle", int'(ld[0]), 0);

    // Same frame, checksum off by one.
    frame(0, 0, 1, 0, -1);
    idle(2);
    chk("ready after bad checksum", int'(rdy[0]), 0);
    chk("count after bad checksum", int'(cnt[0]), 1);

    // 00 A5 then A5 5A + frame: repeated SYNC0 keeps hunting for SYNC1.
    send(0, 8'h00);
    send(0, 8'hA5);
    frame(0, 0, 0, 0, -1);
    idle(2);
    chk("count after resync frame", int'(cnt[0]), 2);

    // Random payloads, random inter-byte gaps and noise between frames.
    repeat (3) begin
      garbage($urandom_range(0, 5));
      frame(0, 1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 255)) : 0, 2, -1);
      idle($urandom_range(0, 3));
    end

    // Good frame, then a frame that stalls after 100 payload bytes.
    frame(0, 1, 0, 0, -1);
    idle(1);
    send(0, 8'hA5);
    send(0, 8'h5A);
    for (int i = 0; i < 100; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      wq.push_back('{10'(i), b});
      send(0, b);
    end
    eq.push_back('{2'd2, 8'(m_cnt[0]), 1'b0});
    idle(int'(TO) - 1);
    chk("no early timeout", int'(eto[0]), 0);
    chk("loading during stall", int'(ld[0]), 1);
    idle(1);
    chk("timeout pulse", int'(eto[0]), 1);
    idle(1);
    chk("timeout pulse width", int'(eto[0]), 0);
    chk("loading after timeout", int'(ld[0]), 0);
    chk("ready after timeout", int'(rdy[0]), 0);

    // Reset in the middle of a payload.
    send(0, 8'hA5);
    send(0, 8'h5A);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      wq.push_back('{10'(i), b});
      send(0, b);
    end
    reset = 1'b1;
    idle(1);
    chk("mid reset addr", int'(addr[0]), 0);
    chk("mid reset data", int'(data[0]), 0);
    chk("mid reset we", int'(we[0]), 0);
    chk("mid reset ready", int'(rdy[0]), 0);
    chk("mid reset loading", int'(ld[0]), 0);
    chk("mid reset pulses", int'({done[0], echk[0], eto[0]}), 0);
    chk("mid reset count", int'(cnt[0]), 0);
    reset = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    idle(1);

    // Frame after reset, with a byte arriving exactly in the terminal timeout cycle.
    frame(0, 1, 0, 1, 400);
    idle(2);
    chk("count after post-reset frame", int'(cnt[0]), 1);
    chk("ready after post-reset frame", int'(rdy[0]), 1);

    // 256 back-to-back good frames on the short-frame loader.
    repeat (256) frame(1, 1, 0, 0, -1);
    idle(2);
    chk("count wrap", int'(cnt[1]), 0);
    chk("ready after wrap", int'(rdy[1]), 1);

    idle(5);
    chk("writes drained", wq.size(), 0);
    chk("events drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mnist_frame_loader.md
MNIST_FRAME_LOADER -- requirements
Module: mnist_frame_loader

Interface
REQ-001 Parameter SYNC0, default 8'hA5, first frame-sync byte.
REQ-002 Parameter SYNC1, default 8'h5A, second frame-sync byte.
REQ-003 Parameter FRAME_BYTES, default 784, payload bytes per frame (28x28 grayscale).
REQ-004 Parameter TIMEOUT_CYCLES, default 24'd5_000_000, idle cycles tolerated between bytes inside a frame.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port rx_valid, input, 1, single-cycle strobe from the Arduino UART receiver; rx_data valid this cycle.
REQ-009 Port rx_data, input, 8, received byte.
REQ-010 Port ram_addr_a, output, 10, write address into mnist_frame_ram Port A, 0..783.
REQ-011 Port ram_data_a, output, 8, grayscale write data.
REQ-012 Port ram_we_a, output, 1, Port A write enable, one cycle per payload byte.
REQ-013 Port frame_ready, output, 1, level: RAM holds a complete checksum-verified frame; drives the blitter's frame_ready.
REQ-014 Port loading, output, 1, high in S_PAYLOAD or S_CHECK.
REQ-015 Port frame_done, output, 1, one-cycle pulse on a good frame.
REQ-016 Port err_checksum, output, 1, one-cycle pulse on checksum mismatch.
REQ-017 Port err_timeout, output, 1, one-cycle pulse on inter-byte timeout.
REQ-018 Port frame_count, output, 8, count of good frames, wraps 255->0.

Function
REQ-019 Frame format: SYNC0, SYNC1, FRAME_BYTES payload bytes in row-major order, one checksum byte = sum of payload mod 256.
REQ-020 States: S_SYNC0, S_SYNC1, S_PAYLOAD, S_CHECK; bytes are consumed only on rx_valid.
REQ-021 S_SYNC0: byte==SYNC0 -> S_SYNC1; any other byte -> stay.
REQ-022 S_SYNC1: byte==SYNC1 -> S_PAYLOAD, clear idx and sum; byte==SYNC0 -> stay; any other byte -> S_SYNC0.
REQ-023 S_PAYLOAD: each byte registers ram_addr_a=idx, ram_data_a=byte, ram_we_a=1 on the next cycle (1-cycle latency); sum+=byte (8-bit wrap); idx==FRAME_BYTES-1 -> S_CHECK, else idx+1.
REQ-024 frame_ready clears in the same cycle the first payload write (idx 0) is issued, so the blitter never starts on a partial frame.
REQ-025 S_CHECK: byte==sum -> frame_ready=1, frame_done pulse, frame_count+1; else err_checksum pulse with frame_ready held 0; both cases -> S_SYNC0; both take effect the cycle after the byte.
REQ-026 Timeout: in S_SYNC1/S_PAYLOAD/S_CHECK, a counter increments on every cycle without rx_valid and clears on rx_valid; on reaching TIMEOUT_CYCLES-1 -> err_timeout pulse, -> S_SYNC0; frame_ready stays 0 if a payload write occurred.
REQ-027 The counter is held at 0 in S_SYNC0; rx_valid in the terminal cycle prevents the timeout.
REQ-028 ram_we_a is 0 in every cycle with no payload write; ram_addr_a/ram_data_a hold their last values.
REQ-029 Sync bytes, checksum bytes and non-frame bytes never cause a RAM write.

Reset
REQ-030 reset -> state S_SYNC0, idx 0, sum 0, timeout counter 0, ram_addr_a 0, ram_data_a 0, ram_we_a 0, frame_ready 0, loading 0, frame_done 0, err_checksum 0, err_timeout 0, frame_count 0.
REQ-031 reset mid-frame aborts the frame and suppresses any pending write; no error pulse.

Structure
REQ-032 Shared package mnist_pkg holds FRAME_BYTES, the default sync constants, and the loader state encoding.
REQ-033 The timeout counter is a sub-module rx_timeout_timer (inputs clk, reset, enable, kick; output expired); all other logic is inline.

Verification
REQ-034 Send A5 5A, payload 0..783 (byte i = i mod 256), checksum = sum mod 256 -> 784 writes with addr i / data i mod 256, then frame_ready=1, frame_done pulse, frame_count=1.
REQ-035 Same frame with checksum+1 -> 784 writes, err_checksum pulse, frame_ready=0, frame_count unchanged.
REQ-036 Stream 00 A5 A5 5A followed by a valid frame -> frame accepted; no write before the payload.
REQ-037 Good frame, then second frame stalled after 100 payload bytes for TIMEOUT_CYCLES (TIMEOUT_CYCLES=50 in the bench) -> frame_ready falls at the first write, err_timeout pulse, state S_SYNC0.
REQ-038 Assert reset after 300 payload bytes -> all outputs at reset values next cycle; next valid frame accepted normally.
REQ-039 Back-to-back bytes every cycle, 256 good frames -> frame_count wraps to 0, no dropped writes.
